// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 5-bit instructions and holds each on instr until op_done.
// Optional watchdog halt on a stalled operation is built when INSTR_SEQ_WATCHDOG_EN is defined.
module instr_sequencer #(
    parameter int                 ADDR_W     = 8,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0,
    parameter int                 WD_CYCLES  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [4:0]        imem_data,
    output logic [4:0]        instr,
    output logic              instr_valid,
    input  logic              op_done,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              halted,
    output logic              illegal,
    output logic              wd_error,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [4:0]        instr_n;
    logic              illegal_n;
    logic              wd_set;
    logic              wd_clr;
    logic              wd_fire;

    // Handshake: instr is held while instr_valid is high; a one-cycle op_done
    // pulse sampled during any ISSUE cycle retires it, no backpressure otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= START_ADDR;
            instr   <= 5'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            instr   <= instr_n;
            illegal <= illegal_n;
        end
    end

`ifdef INSTR_SEQ_WATCHDOG_EN
    localparam int WD_W = ($clog2(WD_CYCLES + 1) > 8) ? $clog2(WD_CYCLES + 1) : 8;
    logic [WD_W-1:0] wd_cnt;

    // Counter restarts as WAIT hands over to ISSUE, so each instruction gets a full budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE && !op_done) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_error <= 1'b0;
        end else if (wd_clr) begin
            wd_error <= 1'b0;
        end else if (wd_set) begin
            wd_error <= 1'b1;
        end
    end

    assign wd_fire = (wd_cnt == WD_W'(WD_CYCLES - 1));
`else
    assign wd_fire  = 1'b0;
    assign wd_error = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        instr_n   = instr;
        illegal_n = illegal;
        wd_set    = 1'b0;
        wd_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FETCH;
                    pc_n    = START_ADDR;
                end
            end
            S_FETCH: state_n = S_WAIT;
            S_WAIT: begin
                state_n = S_ISSUE;
                instr_n = imem_data;
            end
            S_ISSUE: begin
                case (instr[4:2])
                    3'b111: state_n = S_HALT;
                    3'b101, 3'b110: begin
                        state_n   = S_HALT;
                        illegal_n = 1'b1;
                    end
                    default: begin
                        // op_done outranks the watchdog when both land together.
                        if (op_done) begin
                            state_n = S_FETCH;
                            pc_n    = pc + ADDR_W'(1);
                        end else if (wd_fire) begin
                            state_n = S_HALT;
                            wd_set  = 1'b1;
                        end
                    end
                endcase
            end
            S_HALT: begin
                if (start) begin
                    state_n   = S_FETCH;
                    pc_n      = START_ADDR;
                    illegal_n = 1'b0;
                    wd_clr    = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign imem_rd     = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_ISSUE);
    assign running     = (state == S_FETCH) || (state == S_WAIT) || (state == S_ISSUE);
    assign halted      = (state == S_HALT);
    assign dbg_state   = state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table-driven program run plus hand-written corner sequences.
// Define INSTR_SEQ_WATCHDOG_EN to exercise the watchdog variant.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       op_done = 1'b0;
    logic       imem_rd;
    logic [7:0] imem_addr;
    logic [4:0] imem_data = 5'b0;
    logic [4:0] instr;
    logic       instr_valid;
    logic [7:0] pc;
    logic       running, halted, illegal, wd_error;
    logic [2:0] dbg_state;

    logic       start2 = 1'b0;
    logic       op_done2 = 1'b0;
    logic       imem_rd2;
    logic [1:0] imem_addr2;
    logic [4:0] imem_data2 = 5'b0;
    logic [4:0] instr2;
    logic       instr_valid2;
    logic [1:0] pc2;
    logic       running2, halted2, illegal2, wd_error2;
    logic [2:0] dbg_state2;

    logic [4:0] mem  [256];
    logic [4:0] mem2 [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
        if (imem_rd2) imem_data2 <= mem2[imem_addr2];
    end

    instr_sequencer #(.ADDR_W(8), .START_ADDR(8'd0), .WD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid), .op_done(op_done),
        .pc(pc), .running(running), .halted(halted), .illegal(illegal), .wd_error(wd_error),
        .dbg_state(dbg_state)
    );

    instr_sequencer #(.ADDR_W(2), .START_ADDR(2'd0)) dut_wrap (
        .clk(clk), .reset(reset), .start(start2), .imem_rd(imem_rd2), .imem_addr(imem_addr2),
        .imem_data(imem_data2), .instr(instr2), .instr_valid(instr_valid2), .op_done(op_done2),
        .pc(pc2), .running(running2), .halted(halted2), .illegal(illegal2), .wd_error(wd_error2),
        .dbg_state(dbg_state2)
    );

    typedef struct {
        logic       start;
        logic       op_done;
        logic       valid;
        logic [4:0] instr;
        logic [7:0] pc;
        logic       rd;
        logic       running;
        logic       halted;
        logic       illegal;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic s, input logic d, input logic v, input logic [4:0] ins,
                           input logic [7:0] p, input logic rd, input logic run,
                           input logic h, input logic ill);
        vec_t r;
        r.start = s; r.op_done = d; r.valid = v; r.instr = ins; r.pc = p;
        r.rd = rd; r.running = run; r.halted = h; r.illegal = ill;
        vecs.push_back(r);
    endtask

    initial begin
        int cnt;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 5'b0;
        mem[0] = 5'b00001;
        mem[1] = 5'b00110;
        mem[2] = 5'b01101;
        mem[3] = 5'b11100;
        for (int i = 0; i < 4; i++) mem2[i] = 5'b00001;

        //      st d  v  instr    pc rd run h  ill
        add_row(1, 0, 0, 5'h00, 8'd0, 0, 0, 0, 0);  // IDLE, reset values
        add_row(0, 0, 0, 5'h00, 8'd0, 1, 1, 0, 0);  // FETCH
        add_row(0, 0, 0, 5'h00, 8'd0, 0, 1, 0, 0);  // WAIT
        add_row(0, 0, 1, 5'h01, 8'd0, 0, 1, 0, 0);  // ISSUE add
        add_row(0, 0, 1, 5'h01, 8'd0, 0, 1, 0, 0);
        add_row(0, 1, 1, 5'h01, 8'd0, 0, 1, 0, 0);
        add_row(0, 0, 0, 5'h01, 8'd1, 1, 1, 0, 0);
        add_row(0, 0, 0, 5'h01, 8'd1, 0, 1, 0, 0);
        add_row(0, 0, 1, 5'h06, 8'd1, 0, 1, 0, 0);  // sub, 3 cycles after op_done
        add_row(0, 0, 1, 5'h06, 8'd1, 0, 1, 0, 0);
        add_row(0, 1, 1, 5'h06, 8'd1, 0, 1, 0, 0);
        add_row(0, 0, 0, 5'h06, 8'd2, 1, 1, 0, 0);
        add_row(0, 0, 0, 5'h06, 8'd2, 0, 1, 0, 0);
        add_row(0, 0, 1, 5'h0D, 8'd2, 0, 1, 0, 0);  // mult
        add_row(0, 0, 1, 5'h0D, 8'd2, 0, 1, 0, 0);
        add_row(0, 1, 1, 5'h0D, 8'd2, 0, 1, 0, 0);
        add_row(0, 0, 0, 5'h0D, 8'd3, 1, 1, 0, 0);
        add_row(0, 0, 0, 5'h0D, 8'd3, 0, 1, 0, 0);
        add_row(0, 0, 1, 5'h1C, 8'd3, 0, 1, 0, 0);  // stop, one cycle only
        add_row(0, 1, 0, 5'h1C, 8'd3, 0, 0, 1, 0);  // HALT, late op_done ignored
        add_row(0, 0, 0, 5'h1C, 8'd3, 0, 0, 1, 0);

        step();
        step();
        reset = 1'b0;
        check("reset wd_error", wd_error, 0);
        check("reset state", dbg_state, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("row%0d valid", i), instr_valid, vecs[i].valid);
            check($sformatf("row%0d instr", i), instr, vecs[i].instr);
            check($sformatf("row%0d pc", i), pc, vecs[i].pc);
            check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].pc);
            check($sformatf("row%0d imem_rd", i), imem_rd, vecs[i].rd);
            check($sformatf("row%0d running", i), running, vecs[i].running);
            check($sformatf("row%0d halted", i), halted, vecs[i].halted);
            check($sformatf("row%0d illegal", i), illegal, vecs[i].illegal);
            start   = vecs[i].start;
            op_done = vecs[i].op_done;
            step();
        end
        start = 1'b0;
        op_done = 1'b0;

        // Illegal opcode, then restart clears the flag and refetches address 0.
        mem[0] = 5'b10100;
        start = 1'b1; step(); start = 1'b0;
        check("ill fetch addr", imem_addr, 0);
        check("ill fetch rd", imem_rd, 1);
        step(); step();
        check("ill issue valid", instr_valid, 1);
        check("ill issue instr", instr, 5'h14);
        step();
        check("ill halted", halted, 1);
        check("ill flag", illegal, 1);
        check("ill valid low", instr_valid, 0);
        start = 1'b1; step(); start = 1'b0;
        check("ill restart clears", illegal, 0);
        check("ill restart addr", imem_addr, 0);
        check("ill restart rd", imem_rd, 1);

        // Reset during WAIT discards the pending read.
        step();
        check("rst in wait state", dbg_state, 2);
        reset = 1'b1; step(); reset = 1'b0;
        check("rst idle state", dbg_state, 0);
        check("rst valid", instr_valid, 0);
        check("rst instr", instr, 0);
        check("rst running", running, 0);
        op_done = 1'b1; step(); op_done = 1'b0;
        check("late op_done idle", dbg_state, 0);
        check("late op_done pc", pc, 0);

        // op_done coinciding with reset: reset wins and pc returns to start.
        mem[0] = 5'b00001;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check("od+rst first issue", instr, 5'h01);
        op_done = 1'b1; step(); op_done = 1'b0;
        check("od+rst pc advanced", pc, 1);
        step(); step();
        check("od+rst second issue", instr_valid, 1);
        op_done = 1'b1; reset = 1'b1; step(); op_done = 1'b0; reset = 1'b0;
        check("od+rst pc", pc, 0);
        check("od+rst state", dbg_state, 0);

        // Stalled operation: watchdog halt, or indefinite hold without it.
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check("stall issue", instr_valid, 1);
`ifdef INSTR_SEQ_WATCHDOG_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("wd issue %0d", i + 2), instr_valid, 1);
        end
        step();
        check("wd halted", halted, 1);
        check("wd error", wd_error, 1);
        check("wd pc", pc, 0);
        check("wd illegal", illegal, 0);
        start = 1'b1; step(); start = 1'b0;
        check("wd restart clears", wd_error, 0);
`else
        cnt = 1;
        for (int i = 0; i < 99; i++) begin
            step();
            if (instr_valid) cnt++;
        end
        check("hold 100 cycles", cnt, 100);
        check("hold wd_error", wd_error, 0);
`endif
        reset = 1'b1; step(); reset = 1'b0;

        // PC wrap on the 2-bit instance.
        start2 = 1'b1; step(); start2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!imem_rd2 && n < 8) begin step(); n++; end
            check($sformatf("wrap rd %0d", k), imem_rd2, 1);
            check($sformatf("wrap addr %0d", k), imem_addr2, k % 4);
            n = 0;
            while (!instr_valid2 && n < 8) begin step(); n++; end
            check($sformatf("wrap valid %0d", k), instr_valid2, 1);
            op_done2 = 1'b1; step(); op_done2 = 1'b0;
        end
        check("wrap halted", halted2, 0);
        check("wrap illegal", illegal2, 0);
        check("wrap wd_error", wd_error2, 0);
        check("wrap running", running2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
